// File: rtl/gba_rom_responder.sv
// gba_rom_responder: GBA game-pak ROM bus responder. Latches the halfword address on nCS, prefetches
// over a req/ack memory port and auto-increments per read strobe. Define GBA_ROM_WR_EN for the write path.
module gba_rom_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        GBA_nCS,
    input  logic        GBA_nRD,
    input  logic        GBA_nWR,
    input  logic [15:0] GBA_AD_in,
    input  logic [7:0]  GBA_A_in,
    output logic [15:0] ad_out,
    output logic        ad_oe,
    output logic [23:0] mem_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        underrun
);

`ifdef GBA_ROM_WR_EN
    typedef enum logic [2:0] {IDLE, FETCH, READY, DRAIN, WRITE} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, READY, DRAIN} state_t;
`endif

    logic [SYNC_STAGES-1:0]       ncs_sync_q, ncs_sync_d, nrd_sync_q, nrd_sync_d;
    logic [SYNC_STAGES-1:0][23:0] addr_pipe_q, addr_pipe_d;
    logic                         ncs_last_q, nrd_last_q;
    logic                         ncs_s, nrd_s, cs_fall, cs_rise, rd_fall, rd_rise;
    logic [23:0]                  pin_addr;

    state_t      state_q, state_d;
    logic [23:0] addr_q, addr_d, pend_addr_q, pend_addr_d;
    logic [15:0] data_q, data_d;
    logic        mem_req_q, mem_req_d, pend_q, pend_d;
    logic        ad_oe_q, ad_oe_d, underrun_q, underrun_d;

`ifdef GBA_ROM_WR_EN
    logic [SYNC_STAGES-1:0] nwr_sync_q, nwr_sync_d;
    logic                   nwr_last_q, nwr_s, wr_start;
    logic                   mem_we_q, mem_we_d, wr_pend_q, wr_pend_d;
    logic [15:0]            mem_wdata_q, mem_wdata_d, wr_data_q, wr_data_d;

    assign nwr_s     = nwr_sync_q[SYNC_STAGES-1];
    assign wr_start  = ~nwr_last_q & nwr_s & ~ncs_s;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
`else
    logic unused_nwr;
    assign unused_nwr = GBA_nWR;
    assign mem_we     = 1'b0;
    assign mem_wdata  = 16'h0000;
`endif

    // Address/data pipeline matches the strobe synchronizer depth so pin_addr lines up with edges.
    assign ncs_s    = ncs_sync_q[SYNC_STAGES-1];
    assign nrd_s    = nrd_sync_q[SYNC_STAGES-1];
    assign pin_addr = addr_pipe_q[SYNC_STAGES-1];
    assign cs_fall  = ncs_last_q & ~ncs_s;
    assign cs_rise  = ~ncs_last_q & ncs_s;
    assign rd_fall  = nrd_last_q & ~nrd_s;
    assign rd_rise  = ~nrd_last_q & nrd_s;

    assign ad_out   = data_q;
    assign ad_oe    = ad_oe_q;
    assign mem_addr = addr_q;
    assign mem_req  = mem_req_q;
    assign underrun = underrun_q;

    always_comb begin
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], GBA_nCS};
        nrd_sync_d  = {nrd_sync_q[SYNC_STAGES-2:0], GBA_nRD};
        addr_pipe_d = {addr_pipe_q[SYNC_STAGES-2:0], {GBA_A_in, GBA_AD_in}};
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mem_req_d   = mem_req_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        underrun_d  = 1'b0;
        ad_oe_d     = ~ncs_s & ~nrd_s;
`ifdef GBA_ROM_WR_EN
        nwr_sync_d  = {nwr_sync_q[SYNC_STAGES-2:0], GBA_nWR};
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        wr_pend_d   = wr_pend_q;
        wr_data_d   = wr_data_q;
        ad_oe_d     = ~ncs_s & ~nrd_s & nwr_s;
`endif
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    addr_d    = pin_addr;
                    mem_req_d = 1'b1;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                underrun_d = rd_fall & ~mem_ack;
                if (cs_rise) begin
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (mem_ack) begin
                    data_d    = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = READY;
`ifdef GBA_ROM_WR_EN
                    if (wr_pend_q || wr_start) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = wr_pend_q ? wr_data_q : pin_addr[15:0];
                        state_d     = WRITE;
                    end
`endif
                end
`ifdef GBA_ROM_WR_EN
                // A write strobe during a fetch is parked until the read completes.
                if (cs_rise || mem_ack) begin
                    wr_pend_d = 1'b0;
                end else if (wr_start) begin
                    wr_pend_d = 1'b1;
                    wr_data_d = pin_addr[15:0];
                end
`endif
            end
            READY: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else if (rd_rise && !ncs_s) begin
                    addr_d    = addr_q + 24'd1;
                    mem_req_d = 1'b1;
                    state_d   = FETCH;
                end
`ifdef GBA_ROM_WR_EN
                else if (wr_start) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = pin_addr[15:0];
                    state_d     = WRITE;
                end
`endif
            end
            DRAIN: begin
                if (cs_fall) begin
                    pend_d      = 1'b1;
                    pend_addr_d = pin_addr;
                end else if (cs_rise) begin
                    pend_d = 1'b0;
                end
                if (mem_ack) begin
                    pend_d = 1'b0;
`ifdef GBA_ROM_WR_EN
                    mem_we_d = 1'b0;
`endif
                    if (cs_fall || (pend_q && !cs_rise)) begin
                        addr_d    = cs_fall ? pin_addr : pend_addr_q;
                        mem_req_d = 1'b1;
                        state_d   = FETCH;
                    end else begin
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
            end
`ifdef GBA_ROM_WR_EN
            WRITE: begin
                if (cs_rise) begin
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (mem_ack) begin
                    addr_d    = addr_q + 24'd1;
                    mem_we_d  = 1'b0;
                    mem_req_d = 1'b1;
                    state_d   = FETCH;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ncs_sync_q  <= '1;
            nrd_sync_q  <= '1;
            ncs_last_q  <= 1'b1;
            nrd_last_q  <= 1'b1;
            addr_pipe_q <= '0;
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            mem_req_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            ad_oe_q     <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef GBA_ROM_WR_EN
            nwr_sync_q  <= '1;
            nwr_last_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            wr_pend_q   <= 1'b0;
            wr_data_q   <= '0;
`endif
        end else begin
            ncs_sync_q  <= ncs_sync_d;
            nrd_sync_q  <= nrd_sync_d;
            ncs_last_q  <= ncs_s;
            nrd_last_q  <= nrd_s;
            addr_pipe_q <= addr_pipe_d;
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mem_req_q   <= mem_req_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            ad_oe_q     <= ad_oe_d;
            underrun_q  <= underrun_d;
`ifdef GBA_ROM_WR_EN
            nwr_sync_q  <= nwr_sync_d;
            nwr_last_q  <= nwr_s;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            wr_pend_q   <= wr_pend_d;
            wr_data_q   <= wr_data_d;
`endif
        end
    end

endmodule
